// File: rtl/iq_window_accumulator.sv
// iq_window_accumulator: settle/integrate/dump of four signed I/Q streams.
// Optional macro ACC_SAT_EN: saturating accumulators with sticky ovf flags.
module iq_window_accumulator #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 64
) (
   input  logic                     aclk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] in_data_1,
   input  logic signed [DATA_W-1:0] in_data_2,
   input  logic signed [DATA_W-1:0] in_data_3,
   input  logic signed [DATA_W-1:0] in_data_4,
   input  logic [3:0]               in_valid,
   input  logic                     start,
   input  logic [15:0]              settle_len,
   input  logic [31:0]              int_len,
   output logic                     busy,
   output logic [63:0]              val_1,
   output logic [63:0]              val_2,
   output logic [63:0]              val_3,
   output logic [63:0]              val_4,
   output logic [31:0]              cnt_1,
   output logic [31:0]              cnt_2,
   output logic [31:0]              cnt_3,
   output logic [31:0]              cnt_4,
   output logic                     trigger,
   output logic [3:0]               ovf
);

   typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DUMP} state_t;

   state_t                   st;
   logic [31:0]              tmr;
   logic [31:0]              int_q;
   logic signed [DATA_W-1:0] din    [4];
   logic signed [ACC_W-1:0]  acc    [4];
   logic signed [ACC_W-1:0]  acc_nx [4];
   logic [31:0]              smp    [4];
   logic [31:0]              smp_nx [4];
   logic [63:0]              val_q  [4];
   logic [31:0]              cnt_q  [4];

   assign din[0] = in_data_1;
   assign din[1] = in_data_2;
   assign din[2] = in_data_3;
   assign din[3] = in_data_4;

   assign val_1 = val_q[0];
   assign val_2 = val_q[1];
   assign val_3 = val_q[2];
   assign val_4 = val_q[3];
   assign cnt_1 = cnt_q[0];
   assign cnt_2 = cnt_q[1];
   assign cnt_3 = cnt_q[2];
   assign cnt_4 = cnt_q[3];

   // Window length minus one; a zero length behaves as a single cycle.
   function automatic logic [31:0] win_m1(input logic [31:0] len);
      return (len == 32'd0) ? 32'd0 : len - 32'd1;
   endfunction

`ifdef ACC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [3:0]             ovf_q;
   logic [3:0]             sat_hit;
   logic signed [ACC_W:0]  sum [4];

   // Saturating add: one guard bit exposes signed overflow.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         sum[n]     = (ACC_W+1)'(acc[n]) + (ACC_W+1)'(din[n]);
         sat_hit[n] = 1'b0;
         acc_nx[n]  = acc[n];
         if (in_valid[n]) begin
            if (sum[n][ACC_W] != sum[n][ACC_W-1]) begin
               sat_hit[n] = 1'b1;
               acc_nx[n]  = sum[n][ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
               acc_nx[n] = sum[n][ACC_W-1:0];
            end
         end
      end
   end

   assign ovf = ovf_q;
`else
   // Wrapping add modulo 2^ACC_W.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         acc_nx[n] = in_valid[n] ? acc[n] + ACC_W'(din[n]) : acc[n];
      end
   end

   assign ovf = 4'b0000;
`endif

   // Sample counters stick at all-ones instead of wrapping.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         smp_nx[n] = smp[n];
         if (in_valid[n] && (smp[n] != 32'hFFFF_FFFF))
            smp_nx[n] = smp[n] + 32'd1;
      end
   end

   // Measurement sequencer with registered busy/trigger/result outputs.
   always_ff @(posedge aclk) begin
      if (rst) begin
         st      <= IDLE;
         busy    <= 1'b0;
         trigger <= 1'b0;
         tmr     <= 32'd0;
         int_q   <= 32'd0;
         for (int n = 0; n < 4; n++) begin
            acc[n]   <= '0;
            smp[n]   <= '0;
            val_q[n] <= '0;
            cnt_q[n] <= '0;
         end
`ifdef ACC_SAT_EN
         ovf_q <= 4'b0000;
`endif
      end else begin
         trigger <= 1'b0;
         unique case (st)
            IDLE: begin
               if (start) begin
                  busy  <= 1'b1;
                  int_q <= int_len;
                  if (settle_len == 16'd0) begin
                     st  <= ACCUM;
                     tmr <= win_m1(int_len);
                     for (int n = 0; n < 4; n++) begin
                        acc[n] <= '0;
                        smp[n] <= '0;
                     end
`ifdef ACC_SAT_EN
                     ovf_q <= 4'b0000;
`endif
                  end else begin
                     st  <= SETTLE;
                     tmr <= {16'd0, settle_len} - 32'd1;
                  end
               end
            end
            SETTLE: begin
               if (tmr == 32'd0) begin
                  st  <= ACCUM;
                  tmr <= win_m1(int_q);
                  for (int n = 0; n < 4; n++) begin
                     acc[n] <= '0;
                     smp[n] <= '0;
                  end
`ifdef ACC_SAT_EN
                  ovf_q <= 4'b0000;
`endif
               end else begin
                  tmr <= tmr - 32'd1;
               end
            end
            ACCUM: begin
               for (int n = 0; n < 4; n++) begin
                  acc[n] <= acc_nx[n];
                  smp[n] <= smp_nx[n];
               end
`ifdef ACC_SAT_EN
               ovf_q <= ovf_q | sat_hit;
`endif
               if (tmr == 32'd0) begin
                  st      <= DUMP;
                  trigger <= 1'b1;
                  for (int n = 0; n < 4; n++) begin
                     val_q[n] <= 64'(acc_nx[n]);
                     cnt_q[n] <= smp_nx[n];
                  end
               end else begin
                  tmr <= tmr - 32'd1;
               end
            end
            DUMP: begin
               st   <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iq_window_accumulator.sv
// tb_iq_window_accumulator: directed vectors, window model, per-cycle compare.
// Honours ACC_SAT_EN for overflow expectations.
module tb_iq_window_accumulator;

   localparam int     AW   = 40;
   localparam longint AMAX = (longint'(1) <<< (AW-1)) - 1;
   localparam longint AMIN = -(longint'(1) <<< (AW-1));

   logic               clk = 1'b0;
   logic               rst;
   logic signed [31:0] din [4];
   logic [3:0]         in_valid;
   logic               start;
   logic [15:0]        settle_len;
   logic [31:0]        int_len;
   logic               busy;
   logic [63:0]        val [4];
   logic [31:0]        cnt [4];
   logic               trigger;
   logic [3:0]         ovf;

   always #5 clk = ~clk;

   iq_window_accumulator #(.DATA_W(32), .ACC_W(AW)) dut (
      .aclk(clk), .rst(rst),
      .in_data_1(din[0]), .in_data_2(din[1]),
      .in_data_3(din[2]), .in_data_4(din[3]),
      .in_valid(in_valid), .start(start),
      .settle_len(settle_len), .int_len(int_len),
      .busy(busy),
      .val_1(val[0]), .val_2(val[1]), .val_3(val[2]), .val_4(val[3]),
      .cnt_1(cnt[0]), .cnt_2(cnt[1]), .cnt_3(cnt[2]), .cnt_4(cnt[3]),
      .trigger(trigger), .ovf(ovf)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, a, x);
      end
   endtask

   // Model: measurement window bounds and running per-channel results.
   int     ecnt = 0;
   bit     pend = 1'b0;
   longint m_t0, m_ws, m_we, m_T;
   longint run [4];
   longint rc  [4];
   bit [3:0] mov;
   longint eval [4];
   longint ecn  [4];

   always @(posedge clk) begin : model
      longint e, lp, sum;
      ecnt = ecnt + 1;
      e = ecnt;
      if (rst) begin
         pend = 1'b0;
         mov  = 4'b0000;
         for (int n = 0; n < 4; n++) begin
            run[n] = 0; rc[n] = 0; eval[n] = 0; ecn[n] = 0;
         end
      end else begin
         if (start && (!pend || e > m_T)) begin
            pend = 1'b1;
            lp   = (int_len == 0) ? 1 : longint'(int_len);
            m_t0 = e;
            m_ws = e + longint'(settle_len) + 1;
            m_we = m_ws + lp - 1;
            m_T  = m_we + 1;
         end
         if (pend && e == m_ws - 1) begin
            mov = 4'b0000;
            for (int n = 0; n < 4; n++) begin
               run[n] = 0; rc[n] = 0;
            end
         end
         if (pend && e >= m_ws && e <= m_we) begin
            for (int n = 0; n < 4; n++) begin
               if (in_valid[n]) begin
                  sum = run[n] + longint'(din[n]);
`ifdef ACC_SAT_EN
                  if (sum > AMAX) begin
                     run[n] = AMAX; mov[n] = 1'b1;
                  end else if (sum < AMIN) begin
                     run[n] = AMIN; mov[n] = 1'b1;
                  end else begin
                     run[n] = sum;
                  end
`else
                  run[n] = (sum <<< (64-AW)) >>> (64-AW);
`endif
                  if (rc[n] != 64'hFFFF_FFFF) rc[n] = rc[n] + 1;
               end
            end
         end
         if (pend && e == m_we) begin
            for (int n = 0; n < 4; n++) begin
               eval[n] = run[n]; ecn[n] = rc[n];
            end
         end
      end
   end

   // Per-cycle compare of every output against the model.
   bit chk_en = 1'b0;
   int ntrig  = 0;

   always @(negedge clk) begin
      if (chk_en) begin : cmp
         longint c;
         c = ecnt + 1;
         chk("busy", busy, pend && c > m_t0 && c <= m_T);
         chk("trigger", trigger, pend && c == m_T);
         chk("ovf", ovf, mov);
         for (int n = 0; n < 4; n++) begin
            chk($sformatf("val_%0d", n+1), val[n], eval[n]);
            chk($sformatf("cnt_%0d", n+1), cnt[n], ecn[n]);
         end
         if (trigger) ntrig++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input int s, input int l, output longint t0);
      settle_len = 16'(s);
      int_len    = 32'(l);
      start      = 1'b1;
      t0         = ecnt + 1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_trig(input int budget, output longint tc);
      tc = -1;
      for (int i = 0; i < budget; i++) begin
         if (trigger) begin
            tc = ecnt + 1;
            return;
         end
         step();
      end
      checks++;
      errors++;
      $display("FAIL wait_trig: no trigger within %0d cycles", budget);
   endtask

   task automatic nominal(input string tag);
      longint t0, tc;
      din[0] = 32'sd1; din[1] = 32'sd2;
      din[2] = -32'sd3; din[3] = 32'sh7FFF_FFFF;
      in_valid = 4'hF;
      go(2, 4, t0);
      wait_trig(20, tc);
      chk({tag, "_t"}, tc, t0 + 7);
      chk({tag, "_v1"}, val[0], 64'd4);
      chk({tag, "_v2"}, val[1], 64'd8);
      chk({tag, "_v3"}, val[2], 64'hFFFF_FFFF_FFFF_FFF4);
      chk({tag, "_v4"}, val[3], 64'h1_FFFF_FFFC);
      for (int n = 0; n < 4; n++)
         chk($sformatf("%s_c%0d", tag, n+1), cnt[n], 64'd4);
      step();
      step();
   endtask

   initial begin : stim
      longint t0, t1, tc, tc2;
      int n0;
      rst = 1'b1; start = 1'b0; in_valid = 4'h0;
      settle_len = 16'd0; int_len = 32'd0;
      for (int n = 0; n < 4; n++) din[n] = 32'sd0;
      step();
      chk_en = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_busy", busy, 64'd0);
      chk("rst_val1", val[0], 64'd0);
      chk("rst_ovf", ovf, 64'd0);

      nominal("nom");

      for (int n = 0; n < 4; n++) din[n] = 32'sd5;
      in_valid = 4'h0;
      go(0, 8, t0);
      for (int k = 0; k < 8; k++) begin
         in_valid = {(k == 7), 1'b0, (k % 2 == 0), 1'b1};
         step();
      end
      in_valid = 4'h0;
      wait_trig(5, tc);
      chk("sp_t", tc, t0 + 9);
      chk("sp_v1", val[0], 64'd40);
      chk("sp_v2", val[1], 64'd20);
      chk("sp_v3", val[2], 64'd0);
      chk("sp_v4", val[3], 64'd5);
      chk("sp_c1", cnt[0], 64'd8);
      chk("sp_c2", cnt[1], 64'd4);
      chk("sp_c3", cnt[2], 64'd0);
      chk("sp_c4", cnt[3], 64'd1);
      step();
      step();

      din[0] = 32'sd7; din[1] = -32'sd1;
      din[2] = 32'sd100; din[3] = -32'sd100;
      in_valid = 4'hF;
      go(0, 0, t0);
      wait_trig(5, tc);
      chk("z_t", tc, t0 + 2);
      chk("z_v2", val[1], 64'hFFFF_FFFF_FFFF_FFFF);
      for (int n = 0; n < 4; n++)
         chk($sformatf("z_c%0d", n+1), cnt[n], 64'd1);
      step();
      step();

      n0 = ntrig;
      settle_len = 16'd3;
      int_len    = 32'd5;
      start      = 1'b1;
      repeat (9) step();
      start = 1'b0;
      repeat (15) step();
      chk("one_trig", 64'(ntrig - n0), 64'd1);

      go(0, 1, t0);
      wait_trig(5, tc);
      step();
      chk("gap_idle", busy, 64'd0);
      go(0, 1, t1);
      wait_trig(5, tc2);
      chk("b2b_t", tc2, t1 + 2);
      chk("b2b_gap", tc2 - tc, 64'd3);
      step();
      step();

      for (int n = 0; n < 4; n++) din[n] = 32'sd9;
      in_valid = 4'hF;
      go(0, 10, t0);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_busy", busy, 64'd0);
      chk("mr_trig", trigger, 64'd0);
      chk("mr_val1", val[0], 64'd0);
      chk("mr_cnt1", cnt[0], 64'd0);
      n0 = ntrig;
      repeat (15) step();
      chk("mr_notrig", 64'(ntrig - n0), 64'd0);
      nominal("post");

      for (int n = 0; n < 4; n++) din[n] = 32'sd0;
      din[0]   = 32'sh7FFF_FFFF;
      in_valid = 4'h1;
      go(0, 300, t0);
      wait_trig(310, tc);
      chk("of_t", tc, t0 + 301);
      chk("of_c1", cnt[0], 64'd300);
`ifdef ACC_SAT_EN
      chk("of_v1", val[0], 64'h0000_007F_FFFF_FFFF);
      chk("of_ovf", ovf, 64'd1);
`else
      chk("of_v1", val[0], 64'hFFFF_FF95_FFFF_FED4);
      chk("of_ovf", ovf, 64'd0);
`endif
      step();
      step();
      in_valid = 4'h0;
      go(0, 1, t0);
      chk("ovf_clr", ovf, 64'd0);
      wait_trig(5, tc);
      step();
      step();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
